// File: rtl/rst_strap_seq.sv
`timescale 1ns/1ps
// rst_strap_seq: merges button, JTAG srst and PLL lock into one debounced,
//   stretched system reset, and latches the boot straps on every release.
// Latency: release 2+DebounceCycles+StretchCycles edges after the sources go
//   clean; assertion from RUN two edges after the source falls. No backpressure.
// Ports:
//   clk_i, rst_ni        clock and power-on reset (async, active-low)
//   ext_rst_ni           board button, async, active-low
//   jtag_srst_ni         JTAG system reset, async, active-low
//   pll_locked_i         clock generator lock, async
//   strap_spi_i/boot_i   strap pins, async
//   rst_sys_no           registered system reset to the core, active-low
//   strap_spi_o/boot_o   straps latched at the last release
//   strap_valid_o        straps latched and system out of reset
//   rst_cause_o          last cause: 00 POR, 01 button, 10 JTAG, 11 PLL unlock
module rst_strap_seq #(
  parameter int unsigned DebounceCycles = 1000,
  parameter int unsigned StretchCycles  = 32,
  parameter int unsigned CntW           = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ext_rst_ni,
  input  logic       jtag_srst_ni,
  input  logic       pll_locked_i,
  input  logic       strap_spi_i,
  input  logic       strap_boot_i,
  output logic       rst_sys_no,
  output logic       strap_spi_o,
  output logic       strap_boot_o,
  output logic       strap_valid_o,
  output logic [1:0] rst_cause_o
);

  localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] StrLast = CntW'(StretchCycles - 1);

  localparam logic [1:0] CausePll  = 2'b11;
  localparam logic [1:0] CauseJtag = 2'b10;
  localparam logic [1:0] CauseBtn  = 2'b01;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Bit order: {strap_boot, strap_spi, lock, srst, ext}
  logic [4:0] sync_in;
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  assign sync_in = {strap_boot_i, strap_spi_i, pll_locked_i, jtag_srst_ni, ext_rst_ni};

  // Flops reset to 0 so the reset sources read as "active" until the
  // synchronizer has flushed real pin values through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync_in;
      sync2_q <= sync1_q;
    end
  end

  logic ext_s, srst_s, lock_s, strap_spi_s, strap_boot_s;
  assign ext_s        = sync2_q[0];
  assign srst_s       = sync2_q[1];
  assign lock_s       = sync2_q[2];
  assign strap_spi_s  = sync2_q[3];
  assign strap_boot_s = sync2_q[4];

  logic       req;
  logic [1:0] req_cause;

  assign req = !ext_s || !srst_s || !lock_s;

  // Several simultaneous sources: PLL unlock wins, then JTAG, then button.
  always_comb begin
    req_cause = CauseBtn;
    if (!lock_s) begin
      req_cause = CausePll;
    end else if (!srst_s) begin
      req_cause = CauseJtag;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rst_sys_q, rst_sys_d;
  logic            valid_q, valid_d;
  logic            spi_q, spi_d;
  logic            boot_q, boot_d;
  logic [1:0]      cause_q, cause_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_sys_d = rst_sys_q;
    valid_d   = valid_q;
    spi_d     = spi_q;
    boot_d    = boot_q;
    cause_d   = cause_q;

    case (state_q)
      ST_HOLD: begin
        rst_sys_d = 1'b0;
        valid_d   = 1'b0;
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      ST_STRETCH: begin
        rst_sys_d = 1'b0;
        valid_d   = 1'b0;
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = req_cause;
        end else if (cnt_q == StrLast) begin
          // Straps, valid and reset release all move on the same edge.
          state_d   = ST_RUN;
          cnt_d     = '0;
          rst_sys_d = 1'b1;
          valid_d   = 1'b1;
          spi_d     = strap_spi_s;
          boot_d    = strap_boot_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      ST_RUN: begin
        rst_sys_d = 1'b1;
        valid_d   = 1'b1;
        // No debounce on assertion: one synchronized low cycle is enough.
        if (req) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          rst_sys_d = 1'b0;
          valid_d   = 1'b0;
          cause_d   = req_cause;
        end
      end

      default: begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        rst_sys_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      rst_sys_q <= 1'b0;
      valid_q   <= 1'b0;
      spi_q     <= 1'b0;
      boot_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_sys_q <= rst_sys_d;
      valid_q   <= valid_d;
      spi_q     <= spi_d;
      boot_q    <= boot_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_sys_no    = rst_sys_q;
  assign strap_spi_o   = spi_q;
  assign strap_boot_o  = boot_q;
  assign strap_valid_o = valid_q;
  assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_strap_seq.sv
`timescale 1ns/1ps
module tb_rst_strap_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ext_n, srst_n, lock, spi, boot;

  // Small instance used for most scenarios (D=8, S=4).
  logic       s_rst, s_spi, s_boot, s_valid;
  logic [1:0] s_cause;
  // Default-parameter instance used for the POR timing check.
  logic       d_rst, d_spi, d_boot, d_valid;
  logic [1:0] d_cause;

  rst_strap_seq #(.DebounceCycles(8), .StretchCycles(4), .CntW(8)) u_small (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ext_rst_ni   (ext_n),
    .jtag_srst_ni (srst_n),
    .pll_locked_i (lock),
    .strap_spi_i  (spi),
    .strap_boot_i (boot),
    .rst_sys_no   (s_rst),
    .strap_spi_o  (s_spi),
    .strap_boot_o (s_boot),
    .strap_valid_o(s_valid),
    .rst_cause_o  (s_cause)
  );

  rst_strap_seq u_def (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ext_rst_ni   (ext_n),
    .jtag_srst_ni (srst_n),
    .pll_locked_i (lock),
    .strap_spi_i  (spi),
    .strap_boot_i (boot),
    .rst_sys_no   (d_rst),
    .strap_spi_o  (d_spi),
    .strap_boot_o (d_boot),
    .strap_valid_o(d_valid),
    .rst_cause_o  (d_cause)
  );

  // Edge number: 1 on the first rising edge with rst_n high.
  int ecnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  typedef struct {
    int         edge_n;
    logic       spi;
    logic       boot;
    logic [1:0] cause;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the small instance to release; -1 on timeout.
  task automatic wait_rise(input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_rst === 1'b1) begin
        e = ecnt;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ext_n = 1'b1; srst_n = 1'b1; lock = 1'b1;
    spi = 1'b1; boot = 1'b1;
    #2;
    n_vec++;
    if ({s_rst, s_spi, s_boot, s_valid, s_cause} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_small: got %b expected 000000", {s_rst, s_spi, s_boot, s_valid, s_cause});
    end
    n_vec++;
    if ({d_rst, d_spi, d_boot, d_valid, d_cause} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_def: got %b expected 000000", {d_rst, d_spi, d_boot, d_valid, d_cause});
    end
  endtask

  task automatic test_por();
    int s_rise, d_rise;
    logic [4:0] d_out;
    exp_t x;
    s_rise = -1; d_rise = -1; d_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{edge_n: 14, spi: 1'b1, boot: 1'b1, cause: 2'b00});
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (s_rst === 1'b1 && s_rise < 0) s_rise = ecnt;
      if (d_rst === 1'b1 && d_rise < 0) begin
        d_rise = ecnt;
        d_out  = {d_spi, d_boot, d_valid, d_cause};
      end
    end
    n_vec++;
    if (d_rise !== 1034) begin
      n_fail++;
      $display("FAIL por_def_edge: got %0d expected 1034", d_rise);
    end
    n_vec++;
    if (d_out !== 5'b11100) begin
      n_fail++;
      $display("FAIL por_def_outputs: got %b expected 11100", d_out);
    end
    x = sb.pop_front();
    n_vec++;
    if (s_rise !== x.edge_n) begin
      n_fail++;
      $display("FAIL por_small_edge: got %0d expected %0d", s_rise, x.edge_n);
    end
    n_vec++;
    if ({s_spi, s_boot, s_valid, s_cause} !== {x.spi, x.boot, 1'b1, x.cause}) begin
      n_fail++;
      $display("FAIL por_small_outputs: got %b expected %b",
               {s_spi, s_boot, s_valid, s_cause}, {x.spi, x.boot, 1'b1, x.cause});
    end
  endtask

  task automatic test_bounce();
    int e;
    exp_t x;
    @(negedge clk);
    rst_n = 1'b0;
    spi = 1'b1; boot = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      ext_n = (i % 5 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    // Last low was sampled at edge 36: release is 36+2+8+4.
    sb.push_back('{edge_n: 50, spi: 1'b1, boot: 1'b0, cause: 2'b00});
    n_vec++;
    if (s_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_hold: got rst %b expected 0", s_rst);
    end
    wait_rise(40, e);
    x = sb.pop_front();
    n_vec++;
    if (e !== x.edge_n) begin
      n_fail++;
      $display("FAIL bounce_edge: got %0d expected %0d", e, x.edge_n);
    end
    n_vec++;
    if ({s_spi, s_boot, s_valid, s_cause} !== {x.spi, x.boot, 1'b1, x.cause}) begin
      n_fail++;
      $display("FAIL bounce_outputs: got %b expected %b",
               {s_spi, s_boot, s_valid, s_cause}, {x.spi, x.boot, 1'b1, x.cause});
    end
  endtask

  task automatic test_jtag();
    int k, e;
    exp_t x;
    @(negedge clk);
    spi = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({s_rst, s_spi} !== 2'b11) begin
      n_fail++;
      $display("FAIL jtag_strap_ignored_run: got %b expected 11", {s_rst, s_spi});
    end
    @(negedge clk);
    srst_n = 1'b0;
    k = ecnt + 1;
    sb.push_back('{edge_n: k + 14, spi: 1'b0, boot: 1'b0, cause: 2'b10});
    tick();
    @(negedge clk);
    srst_n = 1'b1;
    tick();
    n_vec++;
    if (s_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL jtag_k1: got rst %b expected 1", s_rst);
    end
    tick();
    n_vec++;
    if ({s_rst, s_spi, s_valid, s_cause} !== 5'b01010) begin
      n_fail++;
      $display("FAIL jtag_k2: got %b expected 01010", {s_rst, s_spi, s_valid, s_cause});
    end
    wait_rise(40, e);
    x = sb.pop_front();
    n_vec++;
    if (e !== x.edge_n) begin
      n_fail++;
      $display("FAIL jtag_edge: got %0d expected %0d", e, x.edge_n);
    end
    n_vec++;
    if ({s_spi, s_boot, s_valid, s_cause} !== {x.spi, x.boot, 1'b1, x.cause}) begin
      n_fail++;
      $display("FAIL jtag_outputs: got %b expected %b",
               {s_spi, s_boot, s_valid, s_cause}, {x.spi, x.boot, 1'b1, x.cause});
    end
  endtask

  task automatic test_simul();
    int k, e;
    exp_t x;
    @(negedge clk);
    spi = 1'b1; boot = 1'b1;
    lock = 1'b0; ext_n = 1'b0;
    k = ecnt + 1;
    sb.push_back('{edge_n: k + 14, spi: 1'b1, boot: 1'b1, cause: 2'b11});
    tick();
    @(negedge clk);
    lock = 1'b1; ext_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({s_rst, s_cause} !== 3'b011) begin
      n_fail++;
      $display("FAIL simul_cause: got %b expected 011", {s_rst, s_cause});
    end
    wait_rise(40, e);
    x = sb.pop_front();
    n_vec++;
    if (e !== x.edge_n) begin
      n_fail++;
      $display("FAIL simul_edge: got %0d expected %0d", e, x.edge_n);
    end
    n_vec++;
    if ({s_spi, s_boot, s_valid, s_cause} !== {x.spi, x.boot, 1'b1, x.cause}) begin
      n_fail++;
      $display("FAIL simul_outputs: got %b expected %b",
               {s_spi, s_boot, s_valid, s_cause}, {x.spi, x.boot, 1'b1, x.cause});
    end
  endtask

  task automatic test_stretch_abort();
    int k, e;
    exp_t x;
    @(negedge clk);
    srst_n = 1'b0;
    k = ecnt + 1;
    tick();
    @(negedge clk);
    srst_n = 1'b1;
    // HOLD from edge k+2, STRETCH entered at edge k+10.
    for (int i = 0; i < 20 && ecnt < k + 9; i++) tick();
    @(negedge clk);
    ext_n = 1'b0;
    sb.push_back('{edge_n: k + 24, spi: 1'b1, boot: 1'b1, cause: 2'b01});
    tick();
    @(negedge clk);
    ext_n = 1'b1;
    tick();
    n_vec++;
    if ({s_rst, s_cause} !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_in_stretch: got %b expected 010", {s_rst, s_cause});
    end
    tick();
    n_vec++;
    if ({s_rst, s_cause} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_cause: got %b expected 001", {s_rst, s_cause});
    end
    wait_rise(60, e);
    x = sb.pop_front();
    n_vec++;
    if (e !== x.edge_n) begin
      n_fail++;
      $display("FAIL abort_edge: got %0d expected %0d", e, x.edge_n);
    end
    n_vec++;
    if ({s_spi, s_boot, s_valid, s_cause} !== {x.spi, x.boot, 1'b1, x.cause}) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected %b",
               {s_spi, s_boot, s_valid, s_cause}, {x.spi, x.boot, 1'b1, x.cause});
    end
  endtask

  task automatic test_rst_ni_mid_run();
    int e;
    exp_t x;
    tick();
    tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_rst, s_spi, s_boot, s_valid, s_cause} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 000000", {s_rst, s_spi, s_boot, s_valid, s_cause});
    end
    @(negedge clk);
    spi = 1'b0; boot = 1'b1;
    rst_n = 1'b1;
    sb.push_back('{edge_n: 14, spi: 1'b0, boot: 1'b1, cause: 2'b00});
    wait_rise(40, e);
    x = sb.pop_front();
    n_vec++;
    if (e !== x.edge_n) begin
      n_fail++;
      $display("FAIL rerelease_edge: got %0d expected %0d", e, x.edge_n);
    end
    n_vec++;
    if ({s_spi, s_boot, s_valid, s_cause} !== {x.spi, x.boot, 1'b1, x.cause}) begin
      n_fail++;
      $display("FAIL rerelease_outputs: got %b expected %b",
               {s_spi, s_boot, s_valid, s_cause}, {x.spi, x.boot, 1'b1, x.cause});
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_bounce();
    test_jtag();
    test_simul();
    test_stretch_abort();
    test_rst_ni_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
